// File: rtl/snake_ctrl.sv
// snake_ctrl: button conditioning, direction arbitration, move pacing,
// game state machine and score keeping for the VGA snake datapath.
module snake_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int FRAMES_PER_MOVE = 10,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               up_btn,
    input  logic               down_btn,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic               pause_btn,
    input  logic [9:0]         row,
    input  logic [9:0]         column,
    input  logic               collision_i,
    input  logic               food_eaten_i,
    output logic [2:0]         dir,
    output logic               move_tick,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FRM_W = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRM_W-1:0]   FRM_LAST  = FRM_W'(FRAMES_PER_MOVE - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    localparam logic [2:0] DIR_IDLE  = 3'b000;
    localparam logic [2:0] DIR_DOWN  = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_UP    = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t state, next_state;

    // Bit order: 0 down, 1 left, 2 right, 3 up, 4 pause
    logic [4:0]       raw_btn;
    logic [4:0]       press;
    logic [1:0]       warm;
    logic [2:0]       win_dir;
    logic             win_valid;
    logic             legal;
    logic [2:0]       pending_dir;
    logic [FRM_W-1:0] frame_cnt;
    logic             at_origin;
    logic             at_origin_d;
    logic             frame_start;

    assign raw_btn = {pause_btn, up_btn, right_btn, left_btn, down_btn};

    function automatic logic [2:0] opposite(input logic [2:0] d);
        case (d)
            DIR_DOWN:  opposite = DIR_UP;
            DIR_UP:    opposite = DIR_DOWN;
            DIR_LEFT:  opposite = DIR_RIGHT;
            DIR_RIGHT: opposite = DIR_LEFT;
            default:   opposite = DIR_IDLE;
        endcase
    endfunction

    // Becomes 1 once the synchronizers hold a real post-reset sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) warm <= 2'b00;
        else        warm <= {warm[0], 1'b1};
    end

    // A button only becomes armed after it has been seen released since reset,
    // so a button held through reset never produces a press.
    for (genvar i = 0; i < 5; i++) begin : g_btn
        logic             sync_a;
        logic             sync_b;
        logic             level;
        logic             armed;
        logic             pulse;
        logic [CNT_W-1:0] count;

        // Synchronize, debounce and emit a one-cycle pulse on each accepted rise
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
                level  <= 1'b0;
                armed  <= 1'b0;
                pulse  <= 1'b0;
                count  <= '0;
            end else begin
                sync_a <= raw_btn[i];
                sync_b <= sync_a;
                armed  <= armed | (warm[1] & ~sync_b & ~level);
                pulse  <= 1'b0;
                if (sync_b == level) begin
                    count <= '0;
                end else if (count == DB_LAST) begin
                    count <= '0;
                    level <= sync_b;
                    pulse <= sync_b & armed;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end

        assign press[i] = pulse;
    end

    // Pick one direction press per cycle: DOWN > LEFT > RIGHT > UP
    always_comb begin
        win_dir = DIR_IDLE;
        if (press[0])      win_dir = DIR_DOWN;
        else if (press[1]) win_dir = DIR_LEFT;
        else if (press[2]) win_dir = DIR_RIGHT;
        else if (press[3]) win_dir = DIR_UP;
    end

    assign win_valid = |press[3:0];
    assign legal     = (win_dir != dir) && (win_dir != opposite(dir));

    assign at_origin   = (row == 10'd0) && (column == 10'd0);
    assign frame_start = at_origin & ~at_origin_d;

    // Remember whether pixel 0,0 was present last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) at_origin_d <= 1'b0;
        else        at_origin_d <= at_origin;
    end

    // Game state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Game state transitions; collision outranks a pause press
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (win_valid) next_state = ST_RUN;
            ST_RUN: begin
                if (collision_i)   next_state = ST_OVER;
                else if (press[4]) next_state = ST_PAUSE;
            end
            ST_PAUSE: if (press[4])  next_state = ST_RUN;
            ST_OVER:  if (win_valid) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Direction commit, frame pacing and score, all gated by game state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir         <= DIR_IDLE;
            pending_dir <= DIR_IDLE;
            frame_cnt   <= '0;
            move_tick   <= 1'b0;
            score       <= '0;
        end else begin
            move_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        dir         <= win_dir;
                        pending_dir <= win_dir;
                        frame_cnt   <= '0;
                        score       <= '0;
                    end
                end
                ST_RUN: begin
                    if (food_eaten_i && (score != SCORE_MAX))
                        score <= score + SCORE_W'(1);
                    if (!collision_i) begin
                        if (win_valid && legal)
                            pending_dir <= win_dir;
                        if (frame_start) begin
                            if (frame_cnt == FRM_LAST) begin
                                frame_cnt <= '0;
                                move_tick <= 1'b1;
                                dir       <= pending_dir;
                            end else begin
                                frame_cnt <= frame_cnt + FRM_W'(1);
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (win_valid) begin
                        dir         <= DIR_IDLE;
                        pending_dir <= DIR_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_snake_ctrl.sv
// tb_snake_ctrl: table-driven bench for snake_ctrl with a small expectation queue.
module tb_snake_ctrl;

    localparam int DB = 4;
    localparam int FPM = 3;
    localparam int SW = 2;

    logic          clk;
    logic          rst_n;
    logic          up_btn, down_btn, left_btn, right_btn, pause_btn;
    logic [9:0]    row, column;
    logic          collision_i, food_eaten_i;
    logic [2:0]    dir;
    logic          move_tick;
    logic [1:0]    game_state;
    logic [SW-1:0] score;

    int vec_count   = 0;
    int miscompares = 0;

    typedef enum int {OP_PRESS, OP_FRAME, OP_PULSE} op_t;

    typedef struct {
        string      name;
        op_t        op;
        logic [4:0] btn;
        logic       food;
        logic       coll;
        int         hold;
        logic       tick;
        logic [1:0] st;
        logic [2:0] dir;
        logic [1:0] score;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    snake_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .FRAMES_PER_MOVE(FPM),
        .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .up_btn(up_btn),
        .down_btn(down_btn),
        .left_btn(left_btn),
        .right_btn(right_btn),
        .pause_btn(pause_btn),
        .row(row),
        .column(column),
        .collision_i(collision_i),
        .food_eaten_i(food_eaten_i),
        .dir(dir),
        .move_tick(move_tick),
        .game_state(game_state),
        .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string n, input op_t op, input logic [4:0] b,
                                input logic f, input logic c, input int h, input logic t,
                                input logic [1:0] s, input logic [2:0] d, input logic [1:0] sc);
        vec_t v;
        v.name = n; v.op = op; v.btn = b; v.food = f; v.coll = c; v.hold = h;
        v.tick = t; v.st = s; v.dir = d; v.score = sc;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        vec_count++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive_buttons(input logic [4:0] b);
        {pause_btn, up_btn, right_btn, left_btn, down_btn} = b;
    endtask

    task automatic apply_stimulus(input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        case (v.op)
            OP_PRESS: begin
                drive_buttons(v.btn);
                repeat (DB + 4) step();
                drive_buttons(5'b0);
                repeat (DB + 4) step();
            end
            OP_FRAME: begin
                row = 10'd0;
                column = 10'd0;
                for (int c = 0; c < v.hold; c++) begin
                    step();
                    check_output({v.name, "/tick"}, int'(move_tick), (c == 0) ? int'(v.tick) : 0);
                    if (c == 0 && v.tick)
                        check_output({v.name, "/tick_dir"}, int'(dir), int'(v.dir));
                end
                row = 10'd7;
                column = 10'd9;
                repeat (2) begin
                    step();
                    check_output({v.name, "/tick_off"}, int'(move_tick), 0);
                end
            end
            OP_PULSE: begin
                food_eaten_i = v.food;
                collision_i = v.coll;
                step();
                food_eaten_i = 1'b0;
                collision_i = 1'b0;
                step();
            end
            default: begin
            end
        endcase
        e = exp_q.pop_front();
        check_output({e.name, "/state"}, int'(game_state), int'(e.st));
        check_output({e.name, "/dir"},   int'(dir),        int'(e.dir));
        check_output({e.name, "/score"}, int'(score),      int'(e.score));
    endtask

    initial begin
        // op table: name, op, btn{pause,up,right,left,down}, food, coll, hold, tick, state, dir, score
        vecs.push_back(mk("run_f1",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("run_f2",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("run_f3_hold", OP_FRAME, 5'b00000, 0, 0, 2, 1, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("run_f4",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("run_f5_hold", OP_FRAME, 5'b00000, 0, 0, 3, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("run_f6",      OP_FRAME, 5'b00000, 0, 0, 1, 1, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("rev_left",    OP_PRESS, 5'b00010, 0, 0, 0, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("rev_f1",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("rev_f2",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("rev_f3",      OP_FRAME, 5'b00000, 0, 0, 1, 1, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("prio_up_lt",  OP_PRESS, 5'b01010, 0, 0, 0, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("prio_f1",     OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("prio_f2",     OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("prio_f3",     OP_FRAME, 5'b00000, 0, 0, 1, 1, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("two_up",      OP_PRESS, 5'b01000, 0, 0, 0, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("two_left",    OP_PRESS, 5'b00010, 0, 0, 0, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("two_f1",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("two_f2",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd3, 2'd0));
        vecs.push_back(mk("two_f3",      OP_FRAME, 5'b00000, 0, 0, 1, 1, 2'd1, 3'd4, 2'd0));
        vecs.push_back(mk("pre_pause_f", OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd4, 2'd0));
        vecs.push_back(mk("pause_on",    OP_PRESS, 5'b10000, 0, 0, 0, 0, 2'd2, 3'd4, 2'd0));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk("paused_f", OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd2, 3'd4, 2'd0));
        vecs.push_back(mk("paused_rt",   OP_PRESS, 5'b00100, 0, 0, 0, 0, 2'd2, 3'd4, 2'd0));
        vecs.push_back(mk("pause_off",   OP_PRESS, 5'b10000, 0, 0, 0, 0, 2'd1, 3'd4, 2'd0));
        vecs.push_back(mk("resume_f1",   OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd1, 3'd4, 2'd0));
        vecs.push_back(mk("resume_f2",   OP_FRAME, 5'b00000, 0, 0, 1, 1, 2'd1, 3'd4, 2'd0));
        vecs.push_back(mk("food1",       OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd4, 2'd1));
        vecs.push_back(mk("food2",       OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd4, 2'd2));
        vecs.push_back(mk("food3",       OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd4, 2'd3));
        vecs.push_back(mk("food4_sat",   OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd4, 2'd3));
        vecs.push_back(mk("food5_sat",   OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd4, 2'd3));
        vecs.push_back(mk("coll_food",   OP_PULSE, 5'b00000, 1, 1, 0, 0, 2'd3, 3'd4, 2'd3));
        vecs.push_back(mk("over_f",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd3, 3'd4, 2'd3));
        vecs.push_back(mk("over_down",   OP_PRESS, 5'b00001, 0, 0, 0, 0, 2'd0, 3'd0, 2'd3));
        vecs.push_back(mk("idle_f",      OP_FRAME, 5'b00000, 0, 0, 1, 0, 2'd0, 3'd0, 2'd3));
        vecs.push_back(mk("restart",     OP_PRESS, 5'b00001, 0, 0, 0, 0, 2'd1, 3'd1, 2'd0));
        vecs.push_back(mk("rs_food",     OP_PULSE, 5'b00000, 1, 0, 0, 0, 2'd1, 3'd1, 2'd1));

        rst_n = 1'b0;
        drive_buttons(5'b0);
        row = 10'd7;
        column = 10'd9;
        collision_i = 1'b0;
        food_eaten_i = 1'b0;
        repeat (3) step();
        check_output("reset/state", int'(game_state), 0);
        check_output("reset/dir",   int'(dir),        0);
        check_output("reset/tick",  int'(move_tick),  0);
        check_output("reset/score", int'(score),      0);
        rst_n = 1'b1;
        repeat (4) step();

        for (int i = 0; i < 5; i++)
            apply_stimulus(mk("idle_frame", OP_FRAME, 5'b0, 0, 0, 1, 0, 2'd0, 3'd0, 2'd0));

        // start latency: press pulse at cycle 2+DB, state change one edge later
        drive_buttons(5'b00100);
        repeat (DB + 2) step();
        check_output("start_early/state", int'(game_state), 0);
        step();
        check_output("start/state", int'(game_state), 1);
        check_output("start/dir",   int'(dir),        3);
        step();
        drive_buttons(5'b0);
        repeat (DB + 4) step();

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // asynchronous reset between edges, with DOWN held through it
        step();
        #3;
        rst_n = 1'b0;
        down_btn = 1'b1;
        #1;
        check_output("async_rst/state", int'(game_state), 0);
        check_output("async_rst/dir",   int'(dir),        0);
        check_output("async_rst/tick",  int'(move_tick),  0);
        check_output("async_rst/score", int'(score),      0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step();
        check_output("held_btn/state", int'(game_state), 0);
        check_output("held_btn/dir",   int'(dir),        0);
        down_btn = 1'b0;
        repeat (DB + 4) step();
        apply_stimulus(mk("repress_down", OP_PRESS, 5'b00001, 0, 0, 0, 0, 2'd1, 3'd1, 2'd0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_ctrl.md
# snake_ctrl

Game controller for the VGA snake datapath. It conditions the four raw direction buttons and a pause button, then arbitrates simultaneous presses. It rejects illegal reversals and paces snake movement from VGA frame starts. It also runs the game state machine (IDLE/RUN/PAUSE/OVER) and keeps the score. Its outputs (`dir`, `move_tick`) are what the snake datapath consumes in place of the direct button-edge state register and the datapath-local frame counter.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable synchronized samples required to accept a new button level (≥2).
- `FRAMES_PER_MOVE`, default 10: frame starts per snake step (≥1).
- `SCORE_W`, default 8: score width.
- `clk`  in  1: system/pixel clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `up_btn`, `down_btn`, `left_btn`, `right_btn`  in  1 each: raw asynchronous buttons, active high.
- `pause_btn`  in  1: raw asynchronous pause button, active high.
- `row`  in  10: current VGA row from the VGA driver.
- `column`  in  10: current VGA column from the VGA driver.
- `collision_i`  in  1: datapath flag, head hit body/wall, level.
- `food_eaten_i`  in  1: datapath flag, one-cycle pulse per food eaten.
- `dir`  out  3: committed direction; 000 IDLE, 001 DOWN, 010 LEFT, 011 RIGHT, 100 UP.
- `move_tick`  out  1: one-cycle pulse; the datapath advances the snake once per pulse.
- `game_state`  out  2: 00 IDLE, 01 RUN, 10 PAUSE, 11 OVER.
- `score`  out  SCORE_W: food count.

## Operation
- **Conditioning.** Each button passes through a 2-flop synchronizer followed by a debouncer.
  - Debouncer: a counter clears whenever the synchronized value differs from the debounced level.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value.
  - A press pulse is generated on each debounced 0→1 transition. Releases generate nothing.
- **Arbitration.** If several direction press pulses occur in the same cycle, only one is used, in priority DOWN > LEFT > RIGHT > UP.
- **Frame start.** `frame_start = (row==0 && column==0) && !(previous cycle also row==0 && column==0)`. It fires exactly once per frame, however many clocks the pixel 0,0 is held.
- **Frame counter.** Counts frame_start only in RUN.
  - On the frame_start where the count equals FRAMES_PER_MOVE-1, the count wraps to 0 and `move_tick` is registered high for the next cycle.
- **Pending direction.**
  - In RUN, a winning press updates `pending_dir` only if it is neither equal to nor opposite of the committed `dir` (DOWN/UP, LEFT/RIGHT are opposites).
  - The check is against `dir`, not `pending_dir`, so two quick presses can never produce a reversal.
  - On the edge that raises `move_tick`, `dir` ← `pending_dir`. The new `dir` and the tick are visible in the same cycle.
- **State machine.**
  - IDLE: `dir`=000, no ticks. Any direction press → RUN, with `dir` and `pending_dir` set to that direction, frame counter cleared, score cleared. `pause_btn` is ignored.
  - RUN:
    - `collision_i`=1 in any cycle → OVER. This has priority over everything, including a press in the same cycle.
    - Otherwise a `pause_btn` press → PAUSE.
  - PAUSE: frame counter frozen, no ticks, direction presses ignored, `dir` held. A `pause_btn` press → RUN, and counting resumes from the frozen count.
  - OVER: no ticks, `dir` and score held. Any direction press → IDLE (`dir`=000, which makes the datapath re-initialise). `pause_btn` is ignored.
- **Score.** Increments on `food_eaten_i` only in RUN and saturates at 2^SCORE_W−1. `food_eaten_i` and `collision_i` in the same cycle: score increments and state → OVER.

## Timing
- **Reset values (asynchronous, immediate):** `dir`=000, `move_tick`=0, `game_state`=00, `score`=0. All internal counters, synchronizers, debounced levels, `pending_dir` and the frame-start history are 0.
- **Button latency:** a raw input stable high from cycle 0 gives its press pulse internally at cycle 2+DEBOUNCE_CYCLES. `game_state`/`dir` change on the following edge.
- **Tick latency:** `move_tick` is high one cycle after the qualifying frame_start cycle, for exactly one cycle. Spacing is FRAMES_PER_MOVE frames.
- **Same-cycle events:** a direction press in the same cycle as the tick edge is evaluated against the old `dir`. `pending_dir` updates, but `dir` takes the old `pending_dir`; the new one applies at the next tick.
- **Reset mid-run:** everything returns to reset values at once. A button held through reset deassertion produces no press until it is released and pressed again.

## Test plan
- **Reset/idle.** Use DEBOUNCE_CYCLES=4, FRAMES_PER_MOVE=3. Reset, then run 5 frames with no buttons. Required: `game_state`=00, `dir`=000, no `move_tick`.
- **Start and pacing.** Press RIGHT for 8 cycles. Required:
  - `game_state`=01 and `dir`=011 at cycle 7 after press.
  - `move_tick` on every 3rd frame_start +1 cycle.
  - Holding pixel 0,0 for 2 clocks still counts one frame.
- **Reversal and priority.**
  - In RUN with `dir`=011, press LEFT: required `dir` stays 011 after the next tick.
  - Press UP and LEFT simultaneously: required LEFT wins and is rejected, `dir` stays 011.
  - Press UP then LEFT before a tick: required `dir`=100 at the tick.
- **Pause.**
  - Pause after 1 frame: required no ticks for 10 frames and no effect from direction presses.
  - Unpause: required the first tick arrives after 2 more frames.
- **Score saturation and collision.** Use SCORE_W=2. Send 5 `food_eaten_i` pulses: required `score`=3. Then pulse `collision_i` together with `food_eaten_i`: required `game_state`=11 and `score`=3.
- **Restart and async reset.**
  - In OVER, press DOWN: required `game_state`=00, `dir`=000, `score` held at 3.
  - Press DOWN again: required RUN, `dir`=001, `score`=0.
  - Assert `rst_n` mid-RUN between clock edges: required outputs reset immediately.
